dom_share_encoder: RTL
======================

// Module: dom_share_encoder
// PURPOSE
//   Masking front end for the DOM datapath. Splits plain words into two Boolean shares
//   (a = d ^ m, b = m) using an internal seeded LFSR PRNG.
//   Also supplies the per-cycle fresh randomness (z bits) consumed by downstream DOM gadgets.
//   Sits between the unmasked host interface and the two-share cipher core.
// PARAMETERS
//   WIDTH   20  data word width; share width equals WIDTH
//   RND_W   10  fresh-randomness bits driven on rnd_o per cycle
//   (WIDTH + RND_W <= 64 is required and is checked by an elaboration-time assertion)
// PORTS
//   clk        in   1      clock; all flops are posedge
//   rst_n      in   1      synchronous reset, active-low
//   seed_i     in   64     PRNG seed
//   seed_vld_i in   1      load seed_i into the LFSR this cycle
//   d_i        in   WIDTH  plain data word
//   d_vld_i    in   1      d_i valid
//   d_rdy_o    out  1      encoder accepts d_i
//   sh_a_o     out  WIDTH  share A = d ^ m
//   sh_b_o     out  WIDTH  share B = m
//   sh_vld_o   out  1      share pair valid
//   sh_rdy_i   in   1      downstream accepts the share pair
//   rnd_o      out  RND_W  fresh randomness, refreshed every cycle in RUN
//   seeded_o   out  1      high in RUN state
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge):
//     lfsr=0, state=UNSEEDED, sh_a_o=sh_b_o=0, sh_vld_o=0, rnd_o=0, seeded_o=0.
//   - FSM UNSEEDED:
//     d_rdy_o=0, LFSR frozen.
//     seed_vld_i -> lfsr<=seed_i, state RUN.
//   - FSM RUN:
//     each cycle lfsr <= step(lfsr); step advances the 64-bit Fibonacci LFSR
//     (x^64+x^63+x^61+x^60+1, shift toward MSB, feedback into bit0) by exactly
//     WIDTH+RND_W single-bit shifts, unrolled.
//     m = lfsr[WIDTH-1:0].
//     rnd_o <= lfsr[WIDTH+RND_W-1:WIDTH] (registered, 1-cycle behind lfsr).
//   - RUN + seed_vld_i (reseed):
//     lfsr<=seed_i; d_rdy_o=0 that cycle.
//     A held output pair is untouched; state stays RUN.
//   - Handshake:
//     d_rdy_o = RUN && !seed_vld_i && (!sh_vld_o || sh_rdy_i).
//     On accept (d_vld_i && d_rdy_o): sh_a_o<=d_i^m, sh_b_o<=m, sh_vld_o<=1.
//     Latency is 1 cycle, throughput 1 word/cycle.
//     sh_vld_o clears on sh_rdy_i without a new accept.
//     While sh_vld_o && !sh_rdy_i, sh_a_o/sh_b_o/sh_vld_o hold stable.
//   - Each accepted word uses the m of its accept cycle; masks are never reused.
//   - Security rule: d_i enters only the sh_a_o XOR, never sh_b_o or rnd_o logic.
//     Shares are separately registered.
//   - Reset mid-operation: pending pair is dropped and the FSM returns to UNSEEDED.
//     A reseed is required before new data is accepted.
//   - An all-zero seed locks the LFSR at 0: m=0, so sh_a_o equals plaintext.
//     Behaviour without the optional guard: this case is software's responsibility.
// CONFIGURATION
//   DOM_ENC_SEED_GUARD_EN defined:
//     a seed_i of 0 loads 64'hDEAD_BEEF_0BAD_F00D instead.
//     seeded_o is still set.
//   Not defined:
//     seed_i is loaded verbatim; no substitution logic is present.
// STRUCTURE
//   Package dom_pkg:
//     LFSR_W=64
//     LFSR_TAPS constant
//     SEED_GUARD constant
//     enc_state_t enum {UNSEEDED, RUN}
//     function lfsr_step(state, n)
//   Sub-module dom_lfsr64:
//     seed load, unrolled N-step advance, enable; instantiated once.
//   FSM, handshake and share registers live in the top module.
// TESTING
//   1 Reset, then d_vld_i=1 with no seed -> d_rdy_o=0, sh_vld_o=0, rnd_o=0 throughout.
//   2 Seed 64'h0123_4567_89AB_CDEF, send d_i=20'hABCDE -> next cycle sh_vld_o=1,
//     sh_a_o^sh_b_o=20'hABCDE, sh_b_o equals the lfsr_step reference model.
//   3 Stream 8 words with sh_rdy_i=0 for 3 cycles mid-burst -> held pair is stable,
//     d_rdy_o=0 while stalled, no word lost or duplicated, all 8 pairs recombine correctly.
//   4 Reseed with the same seed mid-stream -> that cycle d_rdy_o=0;
//     subsequent sh_b_o/rnd_o sequence repeats the model from the seed.
//   5 Assert rst_n=0 while sh_vld_o=1 -> next cycle all outputs 0, state UNSEEDED.
//   6 Seed 64'h0: with DOM_ENC_SEED_GUARD_EN sh_b_o is nonzero and matches the
//     SEED_GUARD model; without it sh_b_o=0 and rnd_o=0.

Source files
------------

// File: rtl/dom_pkg.sv
// Shared types, constants and LFSR step helper for the DOM masking front end.
// Optional seed guard is controlled by DOM_ENC_SEED_GUARD_EN in the top module.
package dom_pkg;

    localparam int LFSR_W = 64;

    // Feedback taps for x^64+x^63+x^61+x^60+1 (state bits 63, 62, 60, 59).
    localparam logic [LFSR_W-1:0] LFSR_TAPS  = 64'hD800_0000_0000_0000;
    localparam logic [LFSR_W-1:0] SEED_GUARD = 64'hDEAD_BEEF_0BAD_F00D;

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } enc_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] state,
        input int unsigned       n
    );
        logic [LFSR_W-1:0] s;
        s = state;
        for (int unsigned i = 0; i < n; i++) begin
            s = {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
        end
        return s;
    endfunction

endpackage

// File: rtl/dom_lfsr64.sv
// 64-bit Fibonacci LFSR with seed load and an unrolled N-step advance per enable.
// Load has priority over advance; the register is frozen when neither is asserted.
module dom_lfsr64
    import dom_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_en,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_next;

    assign w_next  = lfsr_step(r_state, N);
    assign o_state = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/dom_share_encoder.sv
// Two-share Boolean masking encoder with seeded LFSR and fresh-randomness output.
// Define DOM_ENC_SEED_GUARD_EN to replace an all-zero seed with a fixed nonzero one.
module dom_share_encoder
    import dom_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int RND_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              seed_vld_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic              d_vld_i,
    output logic              d_rdy_o,
    output logic [WIDTH-1:0]  sh_a_o,
    output logic [WIDTH-1:0]  sh_b_o,
    output logic              sh_vld_o,
    input  logic              sh_rdy_i,
    output logic [RND_W-1:0]  rnd_o,
    output logic              seeded_o
);

    generate
        if (WIDTH + RND_W > LFSR_W || WIDTH < 1 || RND_W < 1) begin : g_bad_cfg
            $error("dom_share_encoder: need 1<=WIDTH, 1<=RND_W, WIDTH+RND_W<=64");
        end
    endgenerate

    enc_state_t        r_state;
    enc_state_t        w_state_nxt;
    logic              w_load;
    logic              w_en;
    logic              w_rdy;
    logic              w_acc;
    logic [LFSR_W-1:0] w_seed;
    logic [LFSR_W-1:0] w_lfsr;
    logic [WIDTH-1:0]  w_m;
    logic [RND_W-1:0]  w_rnd;
    logic              w_unused;

    logic [WIDTH-1:0]  r_sh_a;
    logic [WIDTH-1:0]  r_sh_b;
    logic              r_sh_vld;
    logic [RND_W-1:0]  r_rnd;

`ifdef DOM_ENC_SEED_GUARD_EN
    assign w_seed = (seed_i == '0) ? SEED_GUARD : seed_i;
`else
    assign w_seed = seed_i;
`endif

    dom_lfsr64 #(
        .N (WIDTH + RND_W)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_seed  (w_seed),
        .i_en    (w_en),
        .o_state (w_lfsr)
    );

    // Mask and fresh randomness come from disjoint slices of the same state.
    assign w_m      = w_lfsr[WIDTH-1:0];
    assign w_rnd    = w_lfsr[WIDTH+RND_W-1:WIDTH];
    assign w_unused = ^w_lfsr;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_rdy       = 1'b0;
        unique case (r_state)
            UNSEEDED: begin
                if (seed_vld_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_load = seed_vld_i;
                w_en   = !seed_vld_i;
                w_rdy  = !seed_vld_i && (!r_sh_vld || sh_rdy_i);
            end
        endcase
    end

    assign w_acc = d_vld_i && w_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= UNSEEDED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Share A is the only register that ever sees plaintext.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_a <= '0;
        end else if (w_acc) begin
            r_sh_a <= d_i ^ w_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_b <= '0;
        end else if (w_acc) begin
            r_sh_b <= w_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_vld <= 1'b0;
        end else if (w_acc) begin
            r_sh_vld <= 1'b1;
        end else if (sh_rdy_i) begin
            r_sh_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rnd <= '0;
        end else if (r_state == RUN) begin
            r_rnd <= w_rnd;
        end
    end

    assign d_rdy_o  = w_rdy;
    assign sh_a_o   = r_sh_a;
    assign sh_b_o   = r_sh_b;
    assign sh_vld_o = r_sh_vld;
    assign rnd_o    = r_rnd;
    assign seeded_o = (r_state == RUN);

endmodule
